cpu_writeback: RTL and testbench

//  W-stage pipeline register and register-file write controller for the 16-bit, 8-register CPU.
//  - Accepts the retiring instruction from execute.
//  - Waits for load data when needed.
//  - Drives the single RF write port.
//  - Publishes instr_w and result_w, which the decode-stage hazard/forwarding unit consumes.

---
 rtl/cpu_writeback.sv | 125 ++++++++++++
 tb/tb_cpu_writeback.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_writeback.sv
// W-stage pipeline register and register-file write controller for the 16-bit,
// 8-register CPU; also waits for load data and flags loads that never return.
module cpu_writeback #(
  parameter logic [15:0] NOP_INSTR  = 16'h000F,
  parameter logic [2:0]  LINK_REG   = 3'd7,
  parameter logic [7:0]  LD_TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [15:0] x_instr,
  input  logic [15:0] x_alu_result,
  input  logic [15:0] x_pc_plus,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr_w,
  output logic [15:0] result_w,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        ld_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WB      = 2'd1,
    S_WAIT_LD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ld_err_q, ld_err_d;
  logic        accept;

  function automatic logic is_load(input logic [3:0] op);
    return op == 4'd4;
  endfunction

  function automatic logic is_link(input logic [3:0] op);
    return (op == 4'd8) || (op == 4'd12);
  endfunction

  // mv, add, sub, ld, mvhi target rx; call/callr target the link register
  function automatic logic is_writer(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd12: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  assign x_ready = (state_q != S_WAIT_LD);
  assign accept  = x_valid && x_ready;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    ld_err_d = ld_err_q;
    case (state_q)
      S_IDLE, S_WB: begin
        if (accept) begin
          instr_d = x_instr;
          if (is_load(x_instr[3:0])) begin
            state_d = S_WAIT_LD;
            cnt_d   = 8'd0;
          end else if (is_link(x_instr[3:0])) begin
            state_d  = S_WB;
            result_d = x_pc_plus;
          end else begin
            state_d  = S_WB;
            result_d = x_alu_result;
          end
        end else begin
          state_d = S_IDLE;
          instr_d = NOP_INSTR;
        end
      end
      S_WAIT_LD: begin
        // Data arriving on the final waiting cycle still commits
        if (mem_rvalid) begin
          result_d = mem_rdata;
          state_d  = S_WB;
        end else if (cnt_q == LD_TIMEOUT - 8'd1) begin
          ld_err_d = 1'b1;
          instr_d  = NOP_INSTR;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        instr_d = NOP_INSTR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      instr_q  <= NOP_INSTR;
      result_q <= 16'h0000;
      cnt_q    <= 8'd0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign instr_w  = instr_q;
  assign result_w = result_q;
  assign ld_err   = ld_err_q;
  assign rf_we    = (state_q == S_WB) && is_writer(instr_q[3:0]);
  assign rf_waddr = is_link(instr_q[3:0]) ? LINK_REG : instr_q[7:5];
  assign rf_wdata = result_q;

endmodule

// File: tb/tb_cpu_writeback.sv
// Scenario bench for cpu_writeback: expected RF writes are queued as stimulus is
// driven and retired by a monitor that watches the write port every cycle.
module tb_cpu_writeback;

  logic        clk;
  logic        reset_n;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] x_instr;
  logic [15:0] x_alu_result;
  logic [15:0] x_pc_plus;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [15:0] instr_w;
  logic [15:0] result_w;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        ld_err;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];

  localparam logic [15:0] NOP = 16'h000F;

  cpu_writeback dut (
    .clk(clk), .reset_n(reset_n), .x_valid(x_valid), .x_ready(x_ready),
    .x_instr(x_instr), .x_alu_result(x_alu_result), .x_pc_plus(x_pc_plus),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_w(instr_w),
    .result_w(result_w), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .ld_err(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rx, input logic imm);
    return {5'b0, 3'd1, rx, imm, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: every write must match the oldest expected one
  always @(negedge clk) begin
    if (reset_n && rf_we) begin
      logic [18:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          errors++;
          $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_waddr, rf_wdata, e[18:16], e[15:0]);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({instr_w, result_w, rf_we, rf_waddr, x_ready, ld_err} !== {NOP, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got instr_w=%h result_w=%h rf_we=%b waddr=%0d x_ready=%b ld_err=%b",
               instr_w, result_w, rf_we, rf_waddr, x_ready, ld_err);
    end
    tick();
    reset_n = 1'b1;
    tick();
    x_valid = 1'b1; x_instr = mk(4'd3, 3'd2, 1'b0); x_alu_result = 16'hAAAA;
    tick();
    x_valid = 1'b0;
    checks++;
    if (instr_w !== mk(4'd3, 3'd2, 1'b0) || result_w !== 16'hAAAA) begin
      errors++;
      $display("FAIL reset_pre_load: got instr_w=%h result_w=%h, required %h AAAA",
               instr_w, result_w, mk(4'd3, 3'd2, 1'b0));
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (instr_w !== NOP || result_w !== 16'h0 || rf_we !== 1'b0 || x_ready !== 1'b1 || ld_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcycle: got instr_w=%h result_w=%h rf_we=%b x_ready=%b ld_err=%b",
               instr_w, result_w, rf_we, x_ready, ld_err);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    tick();
    x_valid = 1'b1; x_instr = mk(4'd1, 3'd3, 1'b0); x_alu_result = 16'h1234; x_pc_plus = 16'h7777;
    exp_q.push_back({3'd3, 16'h1234});
    tick();
    x_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL alu_write: got we=%b addr=%0d data=%h, required 1 3 1234", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || instr_w !== NOP) begin
      errors++;
      $display("FAIL alu_bubble: got we=%b instr_w=%h, required 0 %h", rf_we, instr_w, NOP);
    end
  endtask

  task automatic test_load();
    tick();
    x_valid = 1'b1; x_instr = mk(4'd4, 3'd5, 1'b0); x_alu_result = 16'h5555;
    exp_q.push_back({3'd5, 16'hBEEF});
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
      end
      @(negedge clk);
      checks++;
      if (x_ready !== 1'b0 || rf_we !== 1'b0 || result_w !== 16'h1234) begin
        errors++;
        $display("FAIL load_wait[%0d]: got x_ready=%b we=%b result_w=%h, required 0 0 1234",
                 i, x_ready, rf_we, result_w);
      end
      tick();
    end
    mem_rvalid = 1'b0; x_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== 16'hBEEF || x_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_commit: got we=%b addr=%0d data=%h rdy=%b, required 1 5 BEEF 1",
               rf_we, rf_waddr, rf_wdata, x_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL load_single_write: got we=%b, required 0", rf_we);
    end
  endtask

  task automatic test_callr();
    logic [3:0] nonw[9] = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
    tick();
    x_valid = 1'b1; x_instr = mk(4'd12, 3'd2, 1'b1); x_pc_plus = 16'h0042; x_alu_result = 16'h9999;
    exp_q.push_back({3'd7, 16'h0042});
    tick();
    x_instr = mk(4'd8, 3'd1, 1'b0); x_pc_plus = 16'h0100; x_alu_result = 16'h8888;
    exp_q.push_back({3'd7, 16'h0100});
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 3'd7 || rf_wdata !== 16'h0042) begin
      errors++;
      $display("FAIL callr_write: got we=%b addr=%0d data=%h, required 1 7 0042", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    for (int k = 0; k < 9; k++) begin
      x_instr = mk(nonw[k], 3'(k), k[0]); x_alu_result = 16'(k * 16'h1111);
      tick();
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || instr_w !== mk(nonw[k], 3'(k), k[0]) || result_w !== 16'(k * 16'h1111)) begin
        errors++;
        $display("FAIL nonwriter_op%0d: got we=%b instr_w=%h result_w=%h, required we=0",
                 nonw[k], rf_we, instr_w, result_w);
      end
    end
    x_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops[4] = '{4'd0, 4'd1, 4'd2, 4'd6};
    logic [2:0]  rxs[4] = '{3'd0, 3'd1, 3'd2, 3'd6};
    logic [15:0] vals[4] = '{16'h0001, 16'hF002, 16'h0003, 16'hAB04};
    tick();
    for (int k = 0; k < 4; k++) begin
      x_valid = 1'b1; x_instr = mk(ops[k], rxs[k], 1'b1); x_alu_result = vals[k];
      exp_q.push_back({rxs[k], vals[k]});
      tick();
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== rxs[k] || rf_wdata !== vals[k]) begin
        errors++;
        $display("FAIL b2b_write[%0d]: got we=%b addr=%0d data=%h, required 1 %0d %h",
                 k, rf_we, rf_waddr, rf_wdata, rxs[k], vals[k]);
      end
    end
    x_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout_race();
    tick();
    x_valid = 1'b1; x_instr = mk(4'd4, 3'd6, 1'b0);
    tick();
    repeat (63) tick();
    mem_rvalid = 1'b1; mem_rdata = 16'hC0DE;
    exp_q.push_back({3'd6, 16'hC0DE});
    x_valid = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || ld_err !== 1'b0 || instr_w !== mk(4'd4, 3'd6, 1'b0) || rf_wdata !== 16'hC0DE) begin
      errors++;
      $display("FAIL race_commit: got we=%b ld_err=%b instr_w=%h data=%h, required 1 0 ld C0DE",
               rf_we, ld_err, instr_w, rf_wdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    int hit = 0;
    logic [15:0] rsave;
    rsave = result_w;
    tick();
    x_valid = 1'b1; x_instr = mk(4'd4, 3'd4, 1'b0);
    tick();
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (ld_err === 1'b1) begin
        hit = k;
        break;
      end
    end
    x_valid = 1'b0;
    checks++;
    if (hit != 64) begin
      errors++;
      $display("FAIL timeout_cycle: got ld_err after %0d cycles, required 64", hit);
    end
    @(negedge clk);
    checks++;
    if (x_ready !== 1'b1 || instr_w !== NOP || rf_we !== 1'b0 || result_w !== rsave) begin
      errors++;
      $display("FAIL timeout_state: got rdy=%b instr_w=%h we=%b result_w=%h, required 1 %h 0 %h",
               x_ready, instr_w, rf_we, result_w, NOP, rsave);
    end
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    repeat (2) tick();
    checks++;
    if (ld_err !== 1'b1 || instr_w !== NOP || result_w !== rsave || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: got ld_err=%b instr_w=%h result_w=%h we=%b, required 1 %h %h 0",
               ld_err, instr_w, result_w, rf_we, NOP, rsave);
    end
    x_valid = 1'b1; x_instr = mk(4'd1, 3'd1, 1'b0); x_alu_result = 16'h1111;
    exp_q.push_back({3'd1, 16'h1111});
    tick();
    x_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if (result_w !== 16'h1111 || instr_w !== NOP) begin
      errors++;
      $display("FAIL stray_wb: got result_w=%h instr_w=%h, required 1111 %h", result_w, instr_w, NOP);
    end
  endtask

  task automatic test_reset_in_wait();
    tick();
    x_valid = 1'b1; x_instr = mk(4'd4, 3'd3, 1'b0);
    tick();
    repeat (2) tick();
    #2 reset_n = 1'b0;
    x_valid = 1'b0;
    #1;
    checks++;
    if (x_ready !== 1'b1 || instr_w !== NOP || rf_we !== 1'b0 || ld_err !== 1'b0 || result_w !== 16'h0) begin
      errors++;
      $display("FAIL reset_wait_state: got rdy=%b instr_w=%h we=%b ld_err=%b result_w=%h",
               x_ready, instr_w, rf_we, ld_err, result_w);
    end
    tick();
    reset_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 16'h3333;
    tick();
    mem_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || result_w !== 16'h0) begin
        errors++;
        $display("FAIL reset_wait_nowrite[%0d]: got we=%b result_w=%h, required 0 0000", k, rf_we, result_w);
      end
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0; x_valid = 1'b0; x_instr = NOP; x_alu_result = 16'h0;
    x_pc_plus = 16'h0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
    test_reset();
    test_alu();
    test_load();
    test_callr();
    test_back_to_back();
    test_timeout_race();
    test_timeout();
    test_reset_in_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d writes still expected, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
